// File: rtl/mp1_mem_responder.sv
// rtl/mp1_mem_responder.sv - mp1 memory bus responder with programmable latency
// One word-aligned access at a time from an internal word array.
module mp1_mem_responder #(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    LATENCY    = 3,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        err,
    output logic        err_sticky
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, state_next;
    logic [3:0]            count, count_next;
    logic                  resp_next, err_next, accept, enter_resp, abort;
    logic                  op_write, op_oor;
    logic [DEPTH_LOG2-1:0] op_idx;
    logic [3:0]            op_be;
    logic [31:0]           op_wdata;

    logic [31:0]           addr_word;
    logic [DEPTH_LOG2-1:0] in_idx;
    logic                  in_oor;
    logic                  sel_write, sel_oor;
    logic [DEPTH_LOG2-1:0] sel_idx;
    logic [3:0]            sel_be;
    logic [31:0]           sel_wdata;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    assign addr_word = mem_address >> 2;
    assign in_idx    = addr_word[DEPTH_LOG2-1:0];
    assign in_oor    = (addr_word >> DEPTH_LOG2) != 32'd0;

    // With LATENCY=1 the RESP-entry edge is the accepting edge, so use live inputs in IDLE.
    assign sel_write = (state == IDLE) ? mem_write       : op_write;
    assign sel_oor   = (state == IDLE) ? in_oor          : op_oor;
    assign sel_idx   = (state == IDLE) ? in_idx          : op_idx;
    assign sel_be    = (state == IDLE) ? mem_byte_enable : op_be;
    assign sel_wdata = (state == IDLE) ? mem_wdata       : op_wdata;

    assign abort = (state == BUSY) && !(op_write ? mem_write : mem_read);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= 4'd0;
            mem_resp   <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            mem_resp <= resp_next;
            err      <= err_next;
            if (err_next) err_sticky <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        err_next   = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read && mem_write) begin
                    err_next = 1'b1;
                end else if (mem_read || mem_write) begin
                    accept     = 1'b1;
                    count_next = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (abort) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                    err_next   = 1'b1;
                end else if (count == 4'd1) begin
                    state_next = RESP;
                    count_next = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        resp_next = enter_resp;
        if (enter_resp && sel_oor) err_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write <= 1'b0;
            op_oor   <= 1'b0;
            op_idx   <= '0;
            op_be    <= 4'd0;
            op_wdata <= 32'd0;
        end else if (accept) begin
            op_write <= mem_write;
            op_oor   <= in_oor;
            op_idx   <= in_idx;
            op_be    <= mem_byte_enable;
            op_wdata <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata <= 32'd0;
        end else if (enter_resp && !sel_write) begin
            mem_rdata <= sel_oor ? 32'd0 : mem[sel_idx];
        end
    end

    // Array is deliberately not reset; rst_n gate keeps a reset edge from committing a write.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && sel_write && !sel_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_be[i]) mem[sel_idx][8*i +: 8] <= sel_wdata[8*i +: 8];
            end
        end
    end
endmodule
